// File: rtl/median_window_gen.sv
// 3x3 sliding-window generator feeding a serial median stage.
// Raster pixels in, one 9-pixel burst out per interior position.
module median_window_gen #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 16,
  parameter int GAP   = 40
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             FRAME_START,
  input  logic [WIDTH-1:0] PIX_IN,
  input  logic             PIX_VALID,
  output logic             PIX_READY,
  output logic [WIDTH-1:0] DO,
  output logic             DSO,
  output logic             BUSY
);

  localparam int CW = $clog2(IMG_W);
  localparam int PW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_ACCEPT,
    S_EMIT,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic             framed_q, framed_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic [WIDTH-1:0] do_q, do_d;
  logic             dso_q, dso_d;

  logic [WIDTH-1:0] lb0_q [IMG_W];
  logic [WIDTH-1:0] lb1_q [IMG_W];
  logic [WIDTH-1:0] win_q [9];

  logic          accept;
  logic          win_done;
  logic [CW-1:0] eff_col;
  logic [1:0]    eff_row;
  logic [3:0]    nxt;

  assign PIX_READY = nRST && (state_q == S_ACCEPT);
  assign BUSY      = (state_q != S_ACCEPT);
  assign DO        = do_q;
  assign DSO       = dso_q;

  // A frame-start accept behaves as position (0,0) regardless of counters.
  always_comb begin
    accept   = PIX_VALID && PIX_READY;
    eff_col  = FRAME_START ? '0 : col_q;
    eff_row  = FRAME_START ? '0 : row_q;
    win_done = accept && framed_q &&
               (eff_row == 2'd2) && (eff_col >= CW'(2));
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    framed_d = framed_q;
    if (accept) begin
      if (FRAME_START)
        framed_d = 1'b1;
      if (eff_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (eff_row == 2'd2) ? 2'd2 : eff_row + 2'd1;
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end
    end
  end

  // Outputs are computed one step ahead so DSO and DO track the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    do_d    = '0;
    dso_d   = 1'b1;
    nxt     = cnt_q + 4'd1;
    unique case (state_q)
      S_ACCEPT: begin
        if (win_done) begin
          state_d = S_EMIT;
          cnt_d   = 4'd0;
          do_d    = win_q[1];
          dso_d   = 1'b0;
        end
      end
      S_EMIT: begin
        if (cnt_q == 4'd8) begin
          state_d = S_GAP;
          ph_d    = '0;
        end else begin
          cnt_d = nxt;
          do_d  = win_q[nxt];
          dso_d = 1'b0;
        end
      end
      S_GAP: begin
        if (ph_q == PW'(GAP - 1))
          state_d = S_ACCEPT;
        else
          ph_d = ph_q + PW'(1);
      end
      default: state_d = S_ACCEPT;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_ACCEPT;
      col_q    <= '0;
      row_q    <= '0;
      framed_q <= 1'b0;
      cnt_q    <= '0;
      ph_q     <= '0;
      do_q     <= '0;
      dso_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      framed_q <= framed_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      do_q     <= do_d;
      dso_q    <= dso_d;
    end
  end

  // Pixel storage is intentionally left unreset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      lb0_q[eff_col] <= lb1_q[eff_col];
      lb1_q[eff_col] <= PIX_IN;
      win_q[0] <= win_q[1];
      win_q[1] <= win_q[2];
      win_q[2] <= lb0_q[eff_col];
      win_q[3] <= win_q[4];
      win_q[4] <= win_q[5];
      win_q[5] <= lb1_q[eff_col];
      win_q[6] <= win_q[7];
      win_q[7] <= win_q[8];
      win_q[8] <= PIX_IN;
    end
  end

endmodule

// File: tb/tb_median_window_gen.sv
// Directed bench for median_window_gen, IMG_W=4, GAP=40.
// Pixel value equals raster index; bursts captured and compared.
module tb_median_window_gen;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       FRAME_START = 1'b0;
  logic [7:0] PIX_IN = '0;
  logic       PIX_VALID = 1'b0;
  logic       PIX_READY;
  logic [7:0] DO;
  logic       DSO;
  logic       BUSY;

  int n_chk = 0;
  int n_fail = 0;
  int bursts = 0;
  int accepts = 0;
  logic [7:0] cap_q[$];
  logic prev_dso = 1'b1;

  int exp_b[36] = '{0, 1, 2, 4, 5, 6, 8, 9, 10,
                    1, 2, 3, 5, 6, 7, 9, 10, 11,
                    4, 5, 6, 8, 9, 10, 12, 13, 14,
                    5, 6, 7, 9, 10, 11, 13, 14, 15};
  int exp_fs[9] = '{7, 8, 9, 11, 12, 13, 15, 16, 17};

  median_window_gen #(.WIDTH(8), .IMG_W(4), .GAP(40)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .FRAME_START(FRAME_START),
    .PIX_IN(PIX_IN),
    .PIX_VALID(PIX_VALID),
    .PIX_READY(PIX_READY),
    .DO(DO),
    .DSO(DSO),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (nRST && !DSO) begin
      cap_q.push_back(DO);
      if (prev_dso) bursts++;
    end
    prev_dso = DSO;
  end

  always @(posedge CLK)
    if (nRST && PIX_VALID && PIX_READY) accepts++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int v, input logic fs, input bit noisy);
    int guard = 0;
    bit done = 0;
    while (!done) begin
      @(negedge CLK);
      PIX_IN = v[7:0];
      if (PIX_READY) begin
        PIX_VALID = 1'b1;
        FRAME_START = fs;
        @(posedge CLK);
        #1;
        PIX_VALID = 1'b0;
        FRAME_START = 1'b0;
        done = 1;
      end else begin
        PIX_VALID = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
        FRAME_START = noisy ? 1'($urandom_range(0, 1)) : fs;
        guard++;
        if (guard > 200) begin
          chk("push_timeout", guard, 0);
          PIX_VALID = 1'b0;
          done = 1;
        end
      end
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (!BUSY) break;
    end
    chk("idle", int'(BUSY), 0);
  endtask

  task automatic clear_mon();
    cap_q.delete();
    bursts = 0;
    accepts = 0;
  endtask

  task automatic check_frame4(input string tag);
    chk({tag, "_bursts"}, bursts, 4);
    chk({tag, "_accepts"}, accepts, 16);
    chk({tag, "_len"}, cap_q.size(), 36);
    if (cap_q.size() == 36)
      for (int i = 0; i < 36; i++)
        chk($sformatf("%s_do%0d", tag, i), int'(cap_q[i]), exp_b[i]);
  endtask

  initial begin
    int low_n;
    int gap_n;
    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_dso", int'(DSO), 1);
    chk("rst_do", int'(DO), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_ready", int'(PIX_READY), 0);
    nRST = 1'b1;
    #1;
    chk("rel_ready", int'(PIX_READY), 1);

    // Full frame with burst timing measured after index 10
    clear_mon();
    for (int i = 0; i <= 10; i++) push(i, i == 0, 0);
    low_n = 0;
    gap_n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (k == 0) chk("emit_busy", int'(BUSY), 1);
      if (!DSO) low_n++;
      else if (!PIX_READY) gap_n++;
      else break;
    end
    chk("dso_low_cycles", low_n, 9);
    chk("gap_cycles", gap_n, 40);
    chk("ready_after_gap", int'(PIX_READY), 1);
    chk("do_in_accept", int'(DO), 0);
    for (int i = 11; i <= 15; i++) push(i, 1'b0, 0);
    wait_idle();
    check_frame4("frame");

    // Same frame, upstream noise while busy
    clear_mon();
    for (int i = 0; i <= 15; i++) push(i, i == 0, 1);
    wait_idle();
    check_frame4("noisy");

    // Reset during burst cycle 4
    clear_mon();
    for (int i = 0; i <= 10; i++) push(i, i == 0, 0);
    repeat (5) @(negedge CLK);
    chk("burst_w4", int'(DO), 5);
    #1;
    nRST = 1'b0;
    #1;
    chk("abort_dso", int'(DSO), 1);
    chk("abort_do", int'(DO), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_ready", int'(PIX_READY), 0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("abort_rel_ready", int'(PIX_READY), 1);
    clear_mon();
    for (int i = 0; i <= 10; i++) push(i, 1'b0, 0);
    repeat (60) @(negedge CLK);
    chk("no_fs_bursts", bursts, 0);
    clear_mon();
    for (int i = 0; i <= 10; i++) push(i, i == 0, 0);
    wait_idle();
    chk("post_rst_bursts", bursts, 1);
    chk("post_rst_len", cap_q.size(), 9);
    if (cap_q.size() == 9)
      for (int i = 0; i < 9; i++)
        chk($sformatf("post_rst_do%0d", i), int'(cap_q[i]), exp_b[i]);

    // Frame start reasserted at index 7
    clear_mon();
    for (int i = 0; i <= 16; i++) push(i, (i == 0) || (i == 7), 0);
    repeat (60) @(negedge CLK);
    chk("fs7_none_yet", bursts, 0);
    push(17, 1'b0, 0);
    wait_idle();
    chk("fs7_bursts", bursts, 1);
    chk("fs7_len", cap_q.size(), 9);
    if (cap_q.size() == 9)
      for (int i = 0; i < 9; i++)
        chk($sformatf("fs7_do%0d", i), int'(cap_q[i]), exp_fs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/median_window_gen.md
MEDIAN_WINDOW_GEN -- requirements
Module: median_window_gen

Interface
REQ-001 Parameter WIDTH, default 8, pixel bit width.
REQ-002 Parameter IMG_W, default 16, pixels per image line; legal range 3..1024.
REQ-003 Parameter GAP, default 40, number of DSO-high cycles after each window burst; covers the median stage processing time.
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 nRST  input  1  reset, asynchronous, active-low.
REQ-006 FRAME_START  input  1  qualifies the accepted pixel as pixel (row 0, col 0) of a new frame.
REQ-007 PIX_IN  input  WIDTH  raster-order input pixel.
REQ-008 PIX_VALID  input  1  PIX_IN valid this cycle.
REQ-009 PIX_READY  output  1  block accepts a pixel this cycle.
REQ-010 DO  output  WIDTH  serial window pixel to the downstream median stage.
REQ-011 DSO  output  1  window framing: low during the 9 burst cycles, high otherwise.
REQ-012 BUSY  output  1  high while a window burst or gap is in progress.

Function
REQ-013 A pixel is accepted on a rising edge where PIX_VALID=1 and PIX_READY=1; no other input-side state changes occur.
REQ-014 Position counters: col 0..IMG_W-1, row saturating at 2; an accept at col=IMG_W-1 sets col=0 and increments row (saturating); otherwise col increments.
REQ-015 An accept with FRAME_START=1 is treated as col=0, row=0: counters reload and prior window/line data is ignored for window formation.
REQ-016 Two line buffers (IMG_W x WIDTH each): LB1 holds row-1, LB0 holds row-2; on each accept, the old LB1[col] moves to LB0[col] and PIX_IN is written to LB1[col].
REQ-017 A 3x3 register window shifts left one column per accept, loading the new column as {LB0[col], LB1[col], PIX_IN}.
REQ-018 A window is complete when the accepted pixel has row=2 (saturated) and col>=2; border positions produce no window.
REQ-019 FSM states: ACCEPT, EMIT, GAP; the reset state is ACCEPT.
REQ-020 ACCEPT: PIX_READY=1; an accept completing a window -> EMIT on the next edge; otherwise stay.
REQ-021 EMIT: PIX_READY=0; 9 cycles, DSO=0, DO = w0..w8 in row-major order (top-left first, rows oldest to newest, columns oldest to newest); after w8 -> GAP.
REQ-022 GAP: PIX_READY=0, DSO=1, DO=0; GAP cycles, then -> ACCEPT.
REQ-023 DO and DSO are registered; DSO falls on the same edge that presents w0.
REQ-024 BUSY=1 in EMIT and GAP, and 0 in ACCEPT.
REQ-025 In EMIT/GAP, PIX_VALID and FRAME_START are ignored and the upstream holds its data.
REQ-026 Wrap-around: the first window of each new line is emitted only at col=2; the windows from the previous line's last column never mix with those of the new line.
REQ-027 The burst and phase counters are 4-bit and log2(GAP)-bit respectively and wrap only under FSM control; there is no free-running overflow.

Reset
REQ-028 While nRST=0: state=ACCEPT, col=0, row=0, DO=0, DSO=1, BUSY=0, PIX_READY=0.
REQ-029 Reset asserted mid-EMIT or mid-GAP aborts the burst immediately; after release, PIX_READY=1 on the first cycle and FRAME_START is required before a new window.
REQ-030 Line buffer contents are not reset; windows are formed only from pixels accepted since the last FRAME_START.

Verification (IMG_W=4, GAP=40, pixel value = raster index)
REQ-031 4x4 frame, FRAME_START on index 0, PIX_VALID always high -> first burst after index 10 is accepted: DO=0,1,2,4,5,6,8,9,10 with DSO low 9 cycles.
REQ-032 Same frame -> exactly 4 bursts total, centred on indices 5,6,9,10; the second burst is DO=1,2,3,5,6,7,9,10,11.
REQ-033 Burst timing -> after w8, DSO stays high and PIX_READY=0 for exactly 40 cycles, then PIX_READY=1.
REQ-034 PIX_VALID toggled randomly during EMIT/GAP -> the accept count and burst contents are unchanged from REQ-031 and REQ-032.
REQ-035 nRST pulsed low at burst cycle 4 -> DSO=1, DO=0 immediately; a new frame with FRAME_START then reproduces REQ-031.
REQ-036 FRAME_START reasserted at index 7 of a frame -> no burst until 10 more pixels have been accepted.
